// File: rtl/rate_tick_pkg.sv
// Shared types and helpers for the rate tick generator and its step input stage.
// Holds the FSM state encoding, default counter width and reload-value computation.
package rate_tick_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam int unsigned CNT_W_DEFAULT = 26;

  // A divisor of zero behaves as one; the reload value is D-1 truncated to the counter width.
  function automatic logic [31:0] reload_value(input int unsigned div, input int unsigned cnt_w);
    logic [31:0] d;
    logic [31:0] mask;
    d    = (div == 0) ? 32'd1 : div;
    mask = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    return (d - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Step key conditioning: optional 2-flop synchroniser (RATE_TICK_STEP_SYNC_EN) then registered rise detect.
// Latency 2 cycles from first sampling edge to step_rise with the synchroniser, 0 cycles without; no backpressure.
module step_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic step,
  output logic step_rise
);

  logic step_s;
  logic prev_q;

`ifdef RATE_TICK_STEP_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], step};
    end
  end

  assign step_s = sync_q[1];
`else
  // Caller guarantees step is already synchronous to clock (e.g. from a debouncer).
  assign step_s = step;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_q    <= 1'b0;
      step_rise <= 1'b0;
    end else begin
      prev_q    <= step_s;
      step_rise <= step_s & ~prev_q;
    end
  end

endmodule

// File: rtl/rate_tick_gen.sv
// Counter enable source: one-cycle ticks every D clocks while running, or one tick per step press when stopped.
// First tick D cycles after entering RUNNING; step latency 3 cycles (RATE_TICK_STEP_SYNC_EN) or 1; no backpressure.
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned DIV0  = 50_000_000,
  parameter int unsigned DIV1  = 25_000_000,
  parameter int unsigned DIV2  = 12_500_000,
  parameter int unsigned DIV3  = 6_250_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] rate_sel,
  output logic       enable_out,
  output logic       running
);

  localparam logic [CNT_W-1:0] RELOAD0 = CNT_W'(reload_value(DIV0, CNT_W));
  localparam logic [CNT_W-1:0] RELOAD1 = CNT_W'(reload_value(DIV1, CNT_W));
  localparam logic [CNT_W-1:0] RELOAD2 = CNT_W'(reload_value(DIV2, CNT_W));
  localparam logic [CNT_W-1:0] RELOAD3 = CNT_W'(reload_value(DIV3, CNT_W));

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] reload_sel;
  logic             enable_d;
  logic             running_d;
  logic             step_rise;

  step_edge_sync u_step_edge_sync (
    .clock     (clock),
    .resetn    (resetn),
    .step      (step),
    .step_rise (step_rise)
  );

  // rate_sel only matters on the cycles that load the counter.
  always_comb begin
    case (rate_sel)
      2'd0:    reload_sel = RELOAD0;
      2'd1:    reload_sel = RELOAD1;
      2'd2:    reload_sel = RELOAD2;
      default: reload_sel = RELOAD3;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_STOPPED;
      cnt_q      <= '0;
      enable_out <= 1'b0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enable_out <= enable_d;
      running    <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: if (run)  state_d = ST_RUNNING;
      ST_RUNNING: if (!run) state_d = ST_STOPPED;
      default:              state_d = ST_STOPPED;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    enable_d  = 1'b0;
    running_d = (state_d == ST_RUNNING);
    case (state_q)
      ST_STOPPED: begin
        if (run) begin
          cnt_d = reload_sel;
        end else begin
          // A step edge landing on the entry cycle is dropped by this branch.
          cnt_d    = '0;
          enable_d = step_rise;
        end
      end
      ST_RUNNING: begin
        if (!run) begin
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          cnt_d    = reload_sel;
          enable_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Randomised and directed checks of rate_tick_gen against an edge-indexed behavioural model.
module tb_rate_tick_gen;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 3;
  localparam int unsigned DIV2 = 7;
  localparam int unsigned DIV3 = 1;
`ifdef RATE_TICK_STEP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       run;
  logic       step;
  logic [1:0] rate_sel;
  logic       enable_out;
  logic       running;

  rate_tick_gen #(
    .CNT_W (8),
    .DIV0  (DIV0),
    .DIV1  (DIV1),
    .DIV2  (DIV2),
    .DIV3  (DIV3)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .run        (run),
    .step       (step),
    .rate_sel   (rate_sel),
    .enable_out (enable_out),
    .running    (running)
  );

  always #5 clock = ~clock;

  // Downstream 8-bit counter stage driven by enable_out.
  logic [7:0] dcnt;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) dcnt <= 8'h00;
    else if (enable_out) dcnt <= dcnt + 8'h01;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pulses[$];
  logic smp[$];
  logic prev_run = 1'b0;
  logic exp_en = 1'b0;
  logic exp_run = 1'b0;
  int   next_tick = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int div_of(input logic [1:0] sel);
    int unsigned d;
    case (sel)
      2'd0:    d = DIV0;
      2'd1:    d = DIV1;
      2'd2:    d = DIV2;
      default: d = DIV3;
    endcase
    return (d == 0) ? 1 : int'(d);
  endfunction

  // True when step was first seen high at edge k (samples before reset count as low).
  function automatic logic rose_at(input int k);
    if (k < 0) return 1'b0;
    if (!smp[k]) return 1'b0;
    if (k == 0) return 1'b1;
    return !smp[k-1];
  endfunction

  // Expected outputs after one rising edge, from the inputs sampled on that edge.
  function automatic void model_edge();
    int   e;
    logic en;
    cyc++;
    if (!resetn) begin
      smp.delete();
      prev_run  = 1'b0;
      exp_en    = 1'b0;
      exp_run   = 1'b0;
      next_tick = 0;
      return;
    end
    smp.push_back(step);
    e  = smp.size() - 1;
    en = 1'b0;
    if (!prev_run && run) begin
      next_tick = e + div_of(rate_sel);
    end else if (prev_run && run) begin
      if (e == next_tick) begin
        en        = 1'b1;
        next_tick = e + div_of(rate_sel);
      end
    end else if (!prev_run && !run) begin
      en = rose_at(e - LAT);
    end
    exp_en   = en;
    exp_run  = run;
    prev_run = run;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("enable_out", enable_out, exp_en);
    check("running", running, exp_run);
    if (enable_out) pulses.push_back(cyc);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  function automatic int pulse_at(input int idx);
    if (idx < pulses.size()) return pulses[idx];
    return -1;
  endfunction

  int n_start;
  int p0;
  int e1;
  int e2;

  initial begin
    resetn   = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    rate_sel = 2'd0;
    do_reset();

    // Idle: nothing may tick.
    p0 = pulses.size();
    repeat (100) tick();
    check("idle_pulses", pulses.size() - p0, 0);
    check("idle_running", running, 1'b0);

    // D=4 free run.
    do_reset();
    rate_sel = 2'd0;
    run      = 1'b1;
    n_start  = cyc + 1;
    p0       = pulses.size();
    tick();
    check("running_at_entry", running, 1'b1);
    repeat (13) tick();
    check("d4_count", pulses.size() - p0, 3);
    check("d4_p0", pulse_at(p0),     n_start + 4);
    check("d4_p1", pulse_at(p0 + 1), n_start + 8);
    check("d4_p2", pulse_at(p0 + 2), n_start + 12);
    check("d4_dcnt", dcnt, 8'd3);

    // rate_sel 1 -> 2 mid-period: current 3-cycle period completes, then 7.
    do_reset();
    rate_sel = 2'd1;
    run      = 1'b1;
    n_start  = cyc + 1;
    p0       = pulses.size();
    repeat (5) tick();
    rate_sel = 2'd2;
    repeat (17) tick();
    check("sw_count", pulses.size() - p0, 4);
    check("sw_p0", pulse_at(p0),     n_start + 3);
    check("sw_p1", pulse_at(p0 + 1), n_start + 6);
    check("sw_p2", pulse_at(p0 + 2), n_start + 13);
    check("sw_p3", pulse_at(p0 + 3), n_start + 20);

    // Step mode: held key gives one pulse, second press another.
    do_reset();
    run  = 1'b0;
    step = 1'b1;
    e1   = cyc + 1;
    p0   = pulses.size();
    repeat (20) tick();
    step = 1'b0;
    repeat (3) tick();
    step = 1'b1;
    e2   = cyc + 1;
    repeat (5) tick();
    step = 1'b0;
    repeat (2) tick();
    check("step_count", pulses.size() - p0, 2);
    check("step_p0", pulse_at(p0),     e1 + LAT);
    check("step_p1", pulse_at(p0 + 1), e2 + LAT);

    // Step while running is ignored; run drop on the reload edge suppresses the tick.
    do_reset();
    rate_sel = 2'd0;
    run      = 1'b1;
    p0       = pulses.size();
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    run = 1'b0;
    tick();
    check("drop_enable", enable_out, 1'b0);
    check("drop_running", running, 1'b0);
    repeat (6) tick();
    check("drop_count", pulses.size() - p0, 0);

    // D=1: tick every cycle, downstream counter wraps.
    do_reset();
    rate_sel = 2'd3;
    run      = 1'b1;
    p0       = pulses.size();
    repeat (257) tick();
    check("d1_dcnt_ff", dcnt, 8'hFF);
    tick();
    check("d1_dcnt_wrap", dcnt, 8'h00);
    check("d1_count", pulses.size() - p0, 257);
    resetn = 1'b0;
    #1;
    check("async_rst_enable", enable_out, 1'b0);
    check("async_rst_running", running, 1'b0);
    tick();
    resetn = 1'b1;
    run    = 1'b0;
    repeat (5) tick();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 599) == 0) resetn = 1'b0;
      if ($urandom_range(0, 24) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) step = ~step;
      if ($urandom_range(0, 3) == 0) rate_sel = 2'($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
